// File: rtl/apb_pkg.sv
// Shared APB definitions.
// Used by the bus master and by the APB peripherals.
package apb_pkg;

    // Bus-side transfer phase of an APB requester.
    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS,
        APB_DONE
    } e_apb_state;

endpackage

// File: rtl/apb_wait_counter.sv
// ACCESS-phase wait-state counter.
// Flags the last cycle allowed before a transfer is aborted.
module apb_wait_counter #(
    parameter int unsigned limit = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CntW =
        (limit > 0) ? $clog2(limit + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (limit > 0) ? CntW'(limit - 1) : '0;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Clear on a new command; count wait states, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    assign expired = (limit > 0) && (cnt_q == CntLast);

endmodule

// File: rtl/apb_master.sv
// APB requester: core-side command/response to APB transfers.
// Bus and response outputs are all registered.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned addrWidth     = 2,
    parameter int unsigned dataWidth     = 9,
    parameter int unsigned timeoutCycles = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 sel,
    output logic                 enable,
    output logic                 write,
    output logic [addrWidth-1:0] addr,
    output logic [dataWidth-1:0] wdata,
    input  logic [dataWidth-1:0] rdata,
    input  logic                 ready,
    input  logic                 slverr
);

    e_apb_state           state_q;
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [dataWidth-1:0] rsp_rdata_q;
    logic                 sel_q;
    logic                 enable_q;
    logic                 write_q;
    logic [addrWidth-1:0] addr_q;
    logic [dataWidth-1:0] wdata_q;

    logic accept;
    logic cnt_inc;
    logic expired;

    assign accept  = (state_q == APB_IDLE) && cmd_valid && cmd_ready_q;
    assign cnt_inc = (state_q == APB_ACCESS) && !ready && !expired;

    apb_wait_counter #(
        .limit (timeoutCycles)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // Transfer FSM; every bus and response output is a register here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= APB_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                APB_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        sel_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    enable_q <= 1'b1;
                    state_q  <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (ready) begin
                        rsp_rdata_q <= write_q ? '0 : rdata;
                        rsp_err_q   <= slverr;
                        rsp_valid_q <= 1'b1;
                        sel_q       <= 1'b0;
                        enable_q    <= 1'b0;
                        state_q     <= APB_DONE;
                    end else if (expired) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        sel_q       <= 1'b0;
                        enable_q    <= 1'b0;
                        state_q     <= APB_DONE;
                    end
                end
                APB_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= APB_IDLE;
                end
                default: begin
                    state_q <= APB_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign sel       = sel_q;
    assign enable    = enable_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule
